// File: rtl/fetch_queue_pkg.sv
// Shared types and defaults for the fetch-to-decode queue.
package fetch_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_dec_t;

  localparam int unsigned FQ_DEPTH_DEFAULT = 4;

  function automatic logic [63:0] fq_pack(logic [31:0] pc, logic [31:0] inst);
    fetch_dec_t p;
    p.pc   = pc;
    p.inst = inst;
    return p;
  endfunction

endpackage

// File: rtl/fetch_queue_wrap_ptr.sv
// Mod-Depth pointer with explicit wrap, so Depth need not be a power of two.
module fetch_queue_wrap_ptr #(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            inc_i,
  output logic [PtrW-1:0] ptr_o
);

  logic [PtrW-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == PtrW'(Depth - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// Multi-entry fetch-to-decode queue with flush, occupancy and almost-full reporting.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned WIDTH     = $bits(fetch_dec_t),
  parameter int unsigned DEPTH     = FQ_DEPTH_DEFAULT,
  parameter int unsigned AF_THRESH = DEPTH - 1,
  localparam int unsigned PtrW     = $clog2(DEPTH),
  localparam int unsigned CntW     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             enq_valid_i,
  output logic             enq_ready_o,
  input  logic [WIDTH-1:0] enq_data_i,
  output logic             deq_valid_o,
  input  logic             deq_ready_i,
  output logic [WIDTH-1:0] deq_data_o,
  output logic [CntW-1:0]  count_o,
  output logic             almost_full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [CntW-1:0]  count_d, count_q;
  logic             enq_fire, deq_fire;

  // Ready/valid come only from registered count; flush voids both handshakes.
  assign enq_ready_o = (count_q != CntW'(DEPTH));
  assign deq_valid_o = (count_q != '0);
  assign enq_fire    = enq_valid_i && enq_ready_o && !flush_i;
  assign deq_fire    = deq_valid_o && deq_ready_i && !flush_i;

  fetch_queue_wrap_ptr #(
    .Depth (DEPTH)
  ) u_wr_ptr (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clear_i (flush_i),
    .inc_i   (enq_fire),
    .ptr_o   (wr_ptr)
  );

  fetch_queue_wrap_ptr #(
    .Depth (DEPTH)
  ) u_rd_ptr (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clear_i (flush_i),
    .inc_i   (deq_fire),
    .ptr_o   (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (enq_fire && !deq_fire) begin
      count_d = count_q + 1'b1;
    end else if (deq_fire && !enq_fire) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem_q[wr_ptr] <= enq_data_i;
    end
  end

  assign deq_data_o    = mem_q[rd_ptr];
  assign count_o       = count_q;
  assign almost_full_o = (32'(count_q) >= AF_THRESH);

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed table, corner sequences, random vs queue model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // DEPTH=4 instance
  logic fl4 = 0, ev4 = 0, dr4 = 0, er4, dv4, af4;
  logic [63:0] d4 = '0, q4;
  logic [2:0]  c4;
  // DEPTH=3 instance
  logic fl3 = 0, ev3 = 0, dr3 = 0, er3, dv3, af3;
  logic [63:0] d3 = '0, q3;
  logic [1:0]  c3;
  // DEPTH=5 instance
  logic fl5 = 0, ev5 = 0, dr5 = 0, er5, dv5, af5;
  logic [63:0] d5 = '0, q5;
  logic [2:0]  c5;

  fetch_queue #(.DEPTH(4)) u4 (
    .clk(clk), .reset(reset), .flush_i(fl4), .enq_valid_i(ev4), .enq_ready_o(er4),
    .enq_data_i(d4), .deq_valid_o(dv4), .deq_ready_i(dr4), .deq_data_o(q4),
    .count_o(c4), .almost_full_o(af4)
  );
  fetch_queue #(.DEPTH(3)) u3 (
    .clk(clk), .reset(reset), .flush_i(fl3), .enq_valid_i(ev3), .enq_ready_o(er3),
    .enq_data_i(d3), .deq_valid_o(dv3), .deq_ready_i(dr3), .deq_data_o(q3),
    .count_o(c3), .almost_full_o(af3)
  );
  fetch_queue #(.DEPTH(5)) u5 (
    .clk(clk), .reset(reset), .flush_i(fl5), .enq_valid_i(ev5), .enq_ready_o(er5),
    .enq_data_i(d5), .deq_valid_o(dv5), .deq_ready_i(dr5), .deq_data_o(q5),
    .count_o(c5), .almost_full_o(af5)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return ((pc - 32'h100) << 5) + 32'h13;
  endfunction

  function automatic logic [63:0] pl(input logic [31:0] pc);
    return fq_pack(pc, inst_of(pc));
  endfunction

  typedef struct {
    logic        fl, ev, dr;
    logic [31:0] pc;
    int          cnt;
    logic        dv, er, af;
    logic [31:0] epc;
  } vec_t;

  function automatic vec_t mk(input logic fl, input logic ev, input logic [31:0] pc,
                              input logic dr, input int cnt, input logic dv, input logic er,
                              input logic af, input logic [31:0] epc);
    vec_t v;
    v.fl = fl; v.ev = ev; v.pc = pc; v.dr = dr; v.cnt = cnt;
    v.dv = dv; v.er = er; v.af = af; v.epc = epc;
    return v;
  endfunction

  vec_t vecs[18];
  logic [63:0] mq[$];

  initial begin
    // Each row: inputs for the cycle and outputs expected before that cycle's edge.
    vecs[0]  = mk(0, 1, 32'h100, 0, 0, 0, 1, 0, 32'h0);
    vecs[1]  = mk(0, 1, 32'h104, 0, 1, 1, 1, 0, 32'h100);
    vecs[2]  = mk(0, 1, 32'h108, 0, 2, 1, 1, 0, 32'h100);
    vecs[3]  = mk(0, 1, 32'h10C, 0, 3, 1, 1, 1, 32'h100);
    vecs[4]  = mk(0, 1, 32'h110, 0, 4, 1, 0, 1, 32'h100);
    vecs[5]  = mk(0, 1, 32'h110, 1, 4, 1, 0, 1, 32'h100);
    vecs[6]  = mk(0, 1, 32'h110, 1, 3, 1, 1, 1, 32'h104);
    vecs[7]  = mk(0, 0, 32'h0,   1, 3, 1, 1, 1, 32'h108);
    vecs[8]  = mk(0, 0, 32'h0,   1, 2, 1, 1, 0, 32'h10C);
    vecs[9]  = mk(0, 0, 32'h0,   1, 1, 1, 1, 0, 32'h110);
    vecs[10] = mk(0, 0, 32'h0,   0, 0, 0, 1, 0, 32'h0);
    vecs[11] = mk(0, 1, 32'h180, 0, 0, 0, 1, 0, 32'h0);
    vecs[12] = mk(0, 1, 32'h184, 0, 1, 1, 1, 0, 32'h180);
    vecs[13] = mk(1, 1, 32'h200, 1, 2, 1, 1, 0, 32'h180);
    vecs[14] = mk(0, 1, 32'h300, 0, 0, 0, 1, 0, 32'h0);
    vecs[15] = mk(0, 0, 32'h0,   0, 1, 1, 1, 0, 32'h300);
    vecs[16] = mk(0, 0, 32'h0,   1, 1, 1, 1, 0, 32'h300);
    vecs[17] = mk(0, 0, 32'h0,   0, 0, 0, 1, 0, 32'h0);

    #12;
    chk("rst_count", 64'(c4), 64'd0);
    chk("rst_deq_valid", 64'(dv4), 64'd0);
    chk("rst_enq_ready", 64'(er4), 64'd1);
    chk("rst_almost_full", 64'(af4), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table on DEPTH=4
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      fl4 = vecs[i].fl; ev4 = vecs[i].ev; dr4 = vecs[i].dr;
      d4  = vecs[i].ev ? pl(vecs[i].pc) : 64'h0;
      #1;
      chk($sformatf("v%0d_count", i), 64'(c4), 64'(vecs[i].cnt));
      chk($sformatf("v%0d_deq_valid", i), 64'(dv4), 64'(vecs[i].dv));
      chk($sformatf("v%0d_enq_ready", i), 64'(er4), 64'(vecs[i].er));
      chk($sformatf("v%0d_almost_full", i), 64'(af4), 64'(vecs[i].af));
      if (vecs[i].dv) chk($sformatf("v%0d_data", i), q4, pl(vecs[i].epc));
    end
    @(negedge clk);
    fl4 = 0; ev4 = 0; dr4 = 0;

    // Asynchronous reset mid-cycle at count=3
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ev4 = 1; d4 = pl(32'h340 + 32'(4 * i));
    end
    @(negedge clk);
    ev4 = 0;
    #1 chk("pre_arst_count", 64'(c4), 64'd3);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_count", 64'(c4), 64'd0);
    chk("arst_deq_valid", 64'(dv4), 64'd0);
    chk("arst_enq_ready", 64'(er4), 64'd1);
    chk("arst_almost_full", 64'(af4), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    ev4 = 1; d4 = pl(32'h400);
    #1 chk("post_arst_empty", 64'(dv4), 64'd0);
    @(negedge clk);
    ev4 = 0; dr4 = 1;
    #1;
    chk("post_arst_valid", 64'(dv4), 64'd1);
    chk("post_arst_data", q4, pl(32'h400));
    @(negedge clk);
    dr4 = 0;
    #1 chk("post_arst_drained", 64'(c4), 64'd0);

    // Continuous streaming on DEPTH=3 with two entries resident
    @(negedge clk);
    ev3 = 1; d3 = pl(32'h500);
    @(negedge clk);
    d3 = pl(32'h504);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ev3 = 1; dr3 = 1; d3 = pl(32'h508 + 32'(4 * i));
      #1;
      chk($sformatf("st%0d_count", i), 64'(c3), 64'd2);
      chk($sformatf("st%0d_data", i), q3, pl(32'h500 + 32'(4 * i)));
      chk($sformatf("st%0d_enq_ready", i), 64'(er3), 64'd1);
    end
    @(negedge clk);
    ev3 = 0; dr3 = 0;

    // Random traffic on DEPTH=5 against a queue model
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic f, e, r, ef, df;
      logic [63:0] dat;
      @(negedge clk);
      f   = ($urandom_range(0, 19) == 0);
      e   = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 1) == 1);
      dat = {$urandom(), $urandom()};
      fl5 = f; ev5 = e; dr5 = r; d5 = dat;
      #1;
      chk("rnd_count", 64'(c5), 64'(mq.size()));
      chk("rnd_deq_valid", 64'(dv5), 64'(mq.size() != 0));
      chk("rnd_enq_ready", 64'(er5), 64'(mq.size() != 5));
      chk("rnd_almost_full", 64'(af5), 64'(mq.size() >= 4));
      if (mq.size() != 0) chk("rnd_data", q5, mq[0]);
      if (f) begin
        mq.delete();
      end else begin
        ef = e && (mq.size() != 5);
        df = r && (mq.size() != 0);
        if (df) void'(mq.pop_front());
        if (ef) mq.push_back(dat);
      end
    end
    @(negedge clk);
    fl5 = 0; ev5 = 0; dr5 = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
